// File: rtl/package_header_tx_pkg.sv
// Shared constants and types for the package header framer; the receive-side
// checker uses the same tag values and field widths.
package package_header_tx_pkg;

  localparam int EVTNO_W   = 14;
  localparam int SPILLNO_W = 9;

  localparam logic [1:0] HDR0_TAG = 2'b10;
  localparam logic [1:0] HDR1_TAG = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_PAYLOAD
  } state_t;

  function automatic logic [15:0] hdr0_word(input logic [EVTNO_W-1:0] evt);
    return {HDR0_TAG, evt};
  endfunction

  function automatic logic [15:0] hdr1_word(input logic [SPILLNO_W-1:0] spill);
    return {HDR1_TAG, 5'b0, spill};
  endfunction

endpackage

// File: rtl/package_header_tx_trig_pend_cnt.sv
// Saturating pending-trigger counter; a trigger arriving while full is dropped
// and flagged for one cycle on o_ovf.
module trig_pend_cnt #(
  parameter int PEND_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PEND_W-1:0] o_pend,
  output logic              o_ovf
);

  localparam logic [PEND_W-1:0] FULL = '1;

  logic [PEND_W-1:0] r_pend;

  // A simultaneous dequeue frees a slot, so inc+dec at full is not an overflow.
  assign o_ovf  = i_inc && !i_dec && !i_clr && (r_pend == FULL);
  assign o_pend = r_pend;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend <= '0;
    end else if (i_clr) begin
      r_pend <= i_inc ? PEND_W'(1) : '0;
    end else if (i_inc && !i_dec && (r_pend != FULL)) begin
      r_pend <= r_pend + 1'b1;
    end else if (i_dec && !i_inc && (r_pend != '0)) begin
      r_pend <= r_pend - 1'b1;
    end
  end

endmodule

// File: rtl/package_header_tx.sv
// Transmit framer: one package (HDR0, HDR1, NPAYLOAD payload words) per
// accepted trigger, with event/spill numbering restarted at each spill.
module package_header_tx
  import package_header_tx_pkg::*;
#(
  parameter int NPAYLOAD = 16,
  parameter int PEND_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        live_rising,
  input  logic [11:0] spillno,
  input  logic        trig,
  input  logic [15:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        trig_ovf,
  output logic        overlap_err
);

  localparam int                WCNT_W = (NPAYLOAD > 1) ? $clog2(NPAYLOAD) : 1;
  localparam logic [WCNT_W-1:0] LAST   = WCNT_W'(NPAYLOAD - 1);

  state_t               r_state;
  logic [EVTNO_W-1:0]   r_evtno;
  logic [SPILLNO_W-1:0] r_spill_lat;
  logic [EVTNO_W-1:0]   r_hdr_evt;
  logic [SPILLNO_W-1:0] r_hdr_spill;
  logic [WCNT_W-1:0]    r_wcnt;
  logic                 r_skip;
  logic                 r_trig_ovf;
  logic                 r_overlap_err;

  logic [PEND_W-1:0]    w_pend;
  logic                 w_ovf;
  logic                 w_hdr0_acc;
  logic                 w_xfer;
  logic                 w_last_xfer;
  logic                 w_unused;

  assign w_unused    = ^spillno[11:SPILLNO_W];
  assign w_hdr0_acc  = (r_state == S_HDR0) && tx_ready;
  assign w_xfer      = (r_state == S_PAYLOAD) && pl_valid && tx_ready;
  assign w_last_xfer = w_xfer && (r_wcnt == LAST);

  // A package started before live_rising (r_skip) must not consume a trigger
  // counted in the new spill.
  trig_pend_cnt #(.PEND_W(PEND_W)) u_pend (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (live_rising),
    .i_inc  (trig),
    .i_dec  (w_hdr0_acc && !r_skip),
    .o_pend (w_pend),
    .o_ovf  (w_ovf)
  );

  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    pl_ready = 1'b0;
    case (r_state)
      S_HDR0: begin
        tx_valid = 1'b1;
        tx_sop   = 1'b1;
        tx_data  = hdr0_word(r_hdr_evt);
      end
      S_HDR1: begin
        tx_valid = 1'b1;
        tx_data  = hdr1_word(r_hdr_spill);
      end
      S_PAYLOAD: begin
        tx_valid = pl_valid;
        tx_data  = pl_data;
        tx_eop   = (r_wcnt == LAST);
        pl_ready = tx_ready;
      end
      default: ;
    endcase
  end

  assign trig_ovf    = r_trig_ovf;
  assign overlap_err = r_overlap_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_evtno       <= EVTNO_W'(1);
      r_spill_lat   <= '0;
      r_hdr_evt     <= '0;
      r_hdr_spill   <= '0;
      r_wcnt        <= '0;
      r_skip        <= 1'b0;
      r_trig_ovf    <= 1'b0;
      r_overlap_err <= 1'b0;
    end else begin
      if (w_ovf) r_trig_ovf <= 1'b1;
      case (r_state)
        // Launch is held off during live_rising: pend is being cleared and the
        // next package must pick up the restarted numbering.
        S_IDLE: begin
          if ((w_pend != '0) && !live_rising) begin
            r_state     <= S_HDR0;
            r_hdr_evt   <= r_evtno;
            r_hdr_spill <= r_spill_lat;
          end
        end
        S_HDR0: if (tx_ready) r_state <= S_HDR1;
        S_HDR1: begin
          if (tx_ready) begin
            r_state <= S_PAYLOAD;
            r_wcnt  <= '0;
          end
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == LAST) begin
              r_state <= S_IDLE;
              r_skip  <= 1'b0;
              if (!r_skip) r_evtno <= r_evtno + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Spill restart overrides the end-of-package bookkeeping above.
      if (live_rising) begin
        r_evtno       <= EVTNO_W'(1);
        r_spill_lat   <= spillno[SPILLNO_W-1:0];
        r_trig_ovf    <= 1'b0;
        r_overlap_err <= (r_state != S_IDLE) || (w_pend != '0);
        r_skip        <= (r_state != S_IDLE) && !w_last_xfer;
      end
    end
  end

endmodule

// File: tb/tb_package_header_tx.sv
// Directed scoreboard bench for package_header_tx, plus a second instance
// that runs the 14-bit event number through its wrap.
module tb_package_header_tx;

  localparam int NPL = 4;
  localparam int PW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, live_rising, trig, pl_valid, tx_ready;
  logic [11:0] spillno;
  logic [15:0] pl_data;
  logic        pl_ready, tx_valid, tx_sop, tx_eop, trig_ovf, overlap_err;
  logic [15:0] tx_data;

  logic        rst2, live2, trig2, pl_valid2, tx_ready2;
  logic [11:0] spill2;
  logic [15:0] pl_data2;
  logic        pl_ready2, tx_valid2, tx_sop2, tx_eop2, trig_ovf2, overlap2;
  logic [15:0] tx_data2;

  package_header_tx #(.NPAYLOAD(NPL), .PEND_W(PW)) dut (
    .clk(clk), .rst(rst), .live_rising(live_rising), .spillno(spillno),
    .trig(trig), .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .trig_ovf(trig_ovf),
    .overlap_err(overlap_err)
  );

  package_header_tx #(.NPAYLOAD(1), .PEND_W(4)) dut2 (
    .clk(clk), .rst(rst2), .live_rising(live2), .spillno(spill2),
    .trig(trig2), .pl_data(pl_data2), .pl_valid(pl_valid2), .pl_ready(pl_ready2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .tx_sop(tx_sop2), .tx_eop(tx_eop2), .trig_ovf(trig_ovf2),
    .overlap_err(overlap2)
  );

  typedef struct {
    logic [15:0] d;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [13:0] m_evt = 14'd1;
  logic [8:0]  m_spill = 9'd0;
  int          pl_idx = 0;
  int          exp_pl = 0;
  bit          rnd = 1'b0;
  bit          pl_xfer_seen = 1'b0;
  bit          prev_eop = 1'b0;
  bit          prev_hstall = 1'b0;
  logic [15:0] prev_d = '0;
  logic        prev_sop = 1'b0;
  logic [13:0] m2_evt = 14'd1;
  int          n2_pkgs = 0;
  bit          done2 = 1'b0;

  task automatic chkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted word is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    pl_xfer_seen = pl_valid && pl_ready;
    if (rst) begin
      prev_eop    = 1'b0;
      prev_hstall = 1'b0;
    end else begin
      if (prev_eop) begin
        vectors++;
        assert (tx_valid === 1'b0) else begin
          miscompares++;
          $error("FAIL bubble observed tx_valid=%b expected 0", tx_valid);
        end
      end
      if (prev_hstall) begin
        vectors++;
        assert (tx_valid === 1'b1 && tx_data === prev_d && tx_sop === prev_sop) else begin
          miscompares++;
          $error("FAIL hdr_hold observed %h/%b expected %h/%b", tx_data, tx_sop, prev_d, prev_sop);
        end
      end
      if (tx_valid && tx_data[15:14] != 2'b00) begin
        vectors++;
        assert (pl_ready === 1'b0) else begin
          miscompares++;
          $error("FAIL pl_ready_hdr observed %b expected 0", pl_ready);
        end
      end
      if (tx_valid && tx_ready) begin
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("FAIL extra_word observed %h expected none", tx_data);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          assert ({tx_data, tx_sop, tx_eop} === {e.d, e.sop, e.eop}) else begin
            miscompares++;
            $error("FAIL word observed %h sop%b eop%b expected %h sop%b eop%b",
                   tx_data, tx_sop, tx_eop, e.d, e.sop, e.eop);
          end
        end
      end
      prev_eop    = tx_valid && tx_ready && tx_eop;
      prev_hstall = tx_valid && !tx_ready && (tx_data[15:14] != 2'b00);
      prev_d      = tx_data;
      prev_sop    = tx_sop;
    end
  end

  always @(negedge clk) begin
    if (!rst2 && tx_valid2 && tx_ready2 && tx_sop2) begin
      vectors++;
      assert (tx_data2 === {2'b10, m2_evt}) else begin
        miscompares++;
        $error("FAIL wrap_hdr0 observed %h expected %h", tx_data2, {2'b10, m2_evt});
      end
      m2_evt = m2_evt + 14'd1;
      n2_pkgs++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (pl_xfer_seen) pl_idx++;
    pl_data = 16'h3000 + 16'(pl_idx);
    if (rnd) begin
      pl_valid = 1'($urandom_range(0, 1));
      tx_ready = 1'($urandom_range(0, 1));
    end
    trig        = 1'b0;
    live_rising = 1'b0;
  endtask

  task automatic push_pkg();
    sb.push_back('{d: {2'b10, m_evt}, sop: 1'b1, eop: 1'b0});
    sb.push_back('{d: {2'b01, 5'b0, m_spill}, sop: 1'b0, eop: 1'b0});
    for (int k = 0; k < NPL; k++) begin
      sb.push_back('{d: 16'h3000 + 16'(exp_pl), sop: 1'b0, eop: (k == NPL - 1)});
      exp_pl++;
    end
    m_evt = m_evt + 14'd1;
  endtask

  task automatic live(input logic [11:0] s);
    spillno     = s;
    live_rising = 1'b1;
    tick();
    m_evt   = 14'd1;
    m_spill = s[8:0];
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chkw(tag, 16'(sb.size()), 16'd0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; live_rising = 1'b0; trig = 1'b0; spillno = '0;
    pl_valid = 1'b0; tx_ready = 1'b0; pl_data = 16'h3000;
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_tx_valid", tx_valid, 1'b0);
    chkb("rst_pl_ready", pl_ready, 1'b0);
    chkb("rst_sop", tx_sop, 1'b0);
    chkb("rst_eop", tx_eop, 1'b0);
    chkb("rst_trig_ovf", trig_ovf, 1'b0);
    chkb("rst_overlap", overlap_err, 1'b0);
    chkw("rst_tx_data", tx_data, 16'h0000);
    rst = 1'b0;
    tick();

    // single package, latency and header content
    tx_ready = 1'b1; pl_valid = 1'b1;
    live(12'h123);
    chkb("live_clean_overlap", overlap_err, 1'b0);
    trig = 1'b1; push_pkg(); tick();
    chkb("lat_edge1_valid", tx_valid, 1'b0);
    tick();
    chkb("lat_edge2_valid", tx_valid, 1'b1);
    chkb("lat_edge2_sop", tx_sop, 1'b1);
    chkw("hdr0_first", tx_data, 16'h8001);
    tick();
    chkw("hdr1_first", tx_data, 16'h4123);
    drain("drain_single", 100);

    // three back-to-back triggers
    for (int i = 0; i < 3; i++) begin
      trig = 1'b1; push_pkg(); tick();
    end
    drain("drain_three", 200);
    repeat (3) tick();
    chkb("pend_empty_idle", tx_valid, 1'b0);

    // overflow of a 3-deep pending counter while stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_pkg();
    for (int i = 0; i < 5; i++) begin
      trig = 1'b1; tick();
    end
    tick();
    chkb("ovf_set", trig_ovf, 1'b1);
    chkw("stall_hdr0", tx_data, 16'h8005);
    chkb("stall_sop", tx_sop, 1'b1);
    tx_ready = 1'b1;
    drain("drain_ovf", 200);
    repeat (4) tick();
    chkb("ovf_sticky", trig_ovf, 1'b1);

    // random backpressure on both sides
    live(12'h0AB);
    chkb("ovf_cleared", trig_ovf, 1'b0);
    chkb("live_idle_overlap", overlap_err, 1'b0);
    rnd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trig = 1'b1; push_pkg();
      repeat (7) tick();
    end
    drain("drain_random", 800);
    rnd = 1'b0; tx_ready = 1'b1; pl_valid = 1'b1;
    tick();

    // live_rising in the middle of a payload
    trig = 1'b1; push_pkg(); tick();
    repeat (4) tick();
    live(12'h005);
    chkb("overlap_set", overlap_err, 1'b1);
    drain("drain_inflight", 100);
    trig = 1'b1; push_pkg(); tick();
    tick();
    chkw("new_spill_hdr0", tx_data, 16'h8001);
    tick();
    chkw("new_spill_hdr1", tx_data, 16'h4005);
    drain("drain_new_spill", 100);
    chkb("overlap_sticky", overlap_err, 1'b1);

    begin
      int n;
      n = 0;
      while (!done2 && n < 80000) begin
        @(posedge clk);
        n++;
      end
      chkb("wrap_done", done2, 1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Second instance: 16385 packages from reset take evtno 1..16383, 0, 1.
  initial begin
    rst2 = 1'b1; live2 = 1'b0; trig2 = 1'b0; spill2 = '0;
    pl_valid2 = 1'b1; pl_data2 = 16'h0000; tx_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    for (int i = 0; i < 16385; i++) begin
      trig2 = 1'b1;
      @(posedge clk);
      #1;
      trig2 = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (6) @(posedge clk);
    #1;
    chkb("wrap_trig_ovf", trig_ovf2, 1'b0);
    chkb("wrap_overlap", overlap2, 1'b0);
    chkw("wrap_pkg_count", 16'(n2_pkgs), 16'd16385);
    chkw("wrap_next_evt", {2'b00, m2_evt}, 16'd2);
    done2 = 1'b1;
  end

endmodule
